// File: rtl/booth_mul_seq_if.sv
// rtl/booth_mul_seq_if.sv - request/result handshake bundle for the Booth multiplier
interface booth_mul_seq_if #(
    parameter int XLEN = 32
);
    logic                start_i;
    logic [XLEN-1:0]     rs1_i;
    logic [XLEN-1:0]     rs2_i;
    logic [1:0]          mode_i;
    logic                ack_i;
    logic                busy_o;
    logic                valid_o;
    logic [2*XLEN-1:0]   mul_o;
    logic                flag_o;

    modport master (
        output start_i, rs1_i, rs2_i, mode_i, ack_i,
        input  busy_o, valid_o, mul_o, flag_o
    );

    modport slave (
        input  start_i, rs1_i, rs2_i, mode_i, ack_i,
        output busy_o, valid_o, mul_o, flag_o
    );
endinterface

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-2 Booth multiplier, XLEN+1 steps per product
module booth_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_mul_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [XLEN+1:0]   acc;
    logic [XLEN:0]     q;
    logic              q_m1;
    logic [XLEN:0]     mcand;
    logic [CW-1:0]     cnt;
    logic              is_signed;
    logic [2*XLEN-1:0] mul_r;
    logic              flag_r;

    logic              rs1_signed;
    logic              rs2_signed;
    logic [XLEN+1:0]   addend;
    logic [XLEN+1:0]   sum;
    logic [XLEN+1:0]   acc_n;
    logic [XLEN:0]     q_n;
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN:0]     prod_top;
    logic              flag_n;
    logic              last_step;

    // mode 11 decodes exactly like 01; mode 10 keeps rs2 unsigned
    assign rs1_signed = (bus.mode_i != 2'b00);
    assign rs2_signed = bus.mode_i[0];
    assign last_step  = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start_i) state_d = CALC;
            CALC: if (last_step)   state_d = DONE;
            DONE: if (bus.ack_i)   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Accumulator is XLEN+2 wide so +/- of the extended multiplicand cannot wrap
    always_comb begin
        addend = {mcand[XLEN], mcand};
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + addend;
            2'b10:   sum = acc - addend;
            default: sum = acc;
        endcase
    end

    assign acc_n    = {sum[XLEN+1], sum[XLEN+1:1]};
    assign q_n      = {sum[0], q[XLEN:1]};
    assign prod_n   = {acc_n[XLEN-2:0], q_n};
    assign prod_top = prod_n[2*XLEN-1:XLEN-1];

    always_comb begin
        if (is_signed) begin
            flag_n = !((&prod_top) || !(|prod_top));
        end else begin
            flag_n = |prod_n[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            mcand     <= '0;
            cnt       <= '0;
            is_signed <= 1'b0;
            mul_r     <= '0;
            flag_r    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        mcand     <= {rs1_signed & bus.rs1_i[XLEN-1], bus.rs1_i};
                        q         <= {rs2_signed & bus.rs2_i[XLEN-1], bus.rs2_i};
                        acc       <= '0;
                        q_m1      <= 1'b0;
                        cnt       <= CW'(XLEN + 1);
                        is_signed <= rs1_signed;
                    end
                end
                CALC: begin
                    acc  <= acc_n;
                    q    <= q_n;
                    q_m1 <= q[0];
                    cnt  <= cnt - CW'(1);
                    // Result registers only change on the final step, so they hold between ops
                    if (last_step) begin
                        mul_r  <= prod_n;
                        flag_r <= flag_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o  = (state_q != IDLE);
    assign bus.valid_o = (state_q == DONE);
    assign bus.mul_o   = mul_r;
    assign bus.flag_o  = flag_r;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - directed self-checking bench for booth_mul_seq
module tb_booth_mul_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;

    booth_mul_seq_if #(.XLEN(32)) bus32 ();
    booth_mul_seq_if #(.XLEN(8))  bus8  ();

    booth_mul_seq #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    booth_mul_seq #(.XLEN(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m);
        bus32.start_i = 1'b1;
        bus32.rs1_i   = a;
        bus32.rs2_i   = b;
        bus32.mode_i  = m;
        @(negedge clk);
        bus32.start_i = 1'b0;
        bus32.rs1_i   = 32'h0;
        bus32.rs2_i   = 32'h0;
    endtask

    task automatic wait_valid32();
        lat = 0;
        while (!bus32.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic ack32(input string tag);
        bus32.ack_i = 1'b1;
        @(negedge clk);
        bus32.ack_i = 1'b0;
        check({tag, ".busy_after_ack"}, 64'(bus32.busy_o), 64'd0);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic [63:0] em, input logic ef, input string tag);
        start32(a, b, m);
        wait_valid32();
        check({tag, ".latency"}, 64'(lat), 64'd33);
        check({tag, ".mul"}, bus32.mul_o, em);
        check({tag, ".flag"}, 64'(bus32.flag_o), 64'(ef));
        ack32(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus32.start_i = 1'b0; bus32.rs1_i = '0; bus32.rs2_i = '0; bus32.mode_i = 2'b00; bus32.ack_i = 1'b0;
        bus8.start_i  = 1'b0; bus8.rs1_i  = '0; bus8.rs2_i  = '0; bus8.mode_i  = 2'b00; bus8.ack_i  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.mul",   bus32.mul_o, 64'h0);
        check("rst.flag",  64'(bus32.flag_o), 64'd0);
        check("rst.valid", 64'(bus32.valid_o), 64'd0);
        check("rst.busy",  64'(bus32.busy_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run32(32'd7,        32'hFFFF_FFFD, 2'b01, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "s7xm3");
        run32(32'd7,        32'hFFFF_FFFD, 2'b11, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, "mode11");
        run32(32'h8000_0000, 32'h8000_0000, 2'b01, 64'h4000_0000_0000_0000, 1'b1, "minsq_s");
        run32(32'h8000_0000, 32'h8000_0000, 2'b00, 64'h4000_0000_0000_0000, 1'b1, "minsq_u");
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 64'hFFFF_FFFE_0000_0001, 1'b1, "ones_u");
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 64'h0000_0000_0000_0001, 1'b0, "ones_s");
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 64'hFFFF_FFFF_0000_0001, 1'b1, "ones_su");
        run32(32'hFFFF_FFFF, 32'h8000_0000, 2'b01, 64'h0000_0000_8000_0000, 1'b1, "m1xmin_s");
        run32(32'h7FFF_FFFF, 32'h0000_0001, 2'b01, 64'h0000_0000_7FFF_FFFF, 1'b0, "maxx1_s");

        // Handshake: start/ack during CALC ignored, DONE held until ack
        start32(32'd7, 32'hFFFF_FFFD, 2'b01);
        bus32.start_i = 1'b1; bus32.rs1_i = 32'd3; bus32.rs2_i = 32'd5; bus32.mode_i = 2'b00;
        bus32.ack_i = 1'b1;
        @(negedge clk);
        bus32.start_i = 1'b0; bus32.ack_i = 1'b0; bus32.mode_i = 2'b01;
        check("hs.busy_calc", 64'(bus32.busy_o), 64'd1);
        lat = 1;
        while (!bus32.valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hs.latency", 64'(lat), 64'd33);
        check("hs.mul", bus32.mul_o, 64'hFFFF_FFFF_FFFF_FFEB);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hs.hold_valid", 64'(bus32.valid_o), 64'd1);
            check("hs.hold_mul", bus32.mul_o, 64'hFFFF_FFFF_FFFF_FFEB);
        end
        bus32.start_i = 1'b1; bus32.rs1_i = 32'd3; bus32.rs2_i = 32'd5; bus32.mode_i = 2'b00;
        @(negedge clk);
        bus32.start_i = 1'b0;
        check("hs.start_in_done_valid", 64'(bus32.valid_o), 64'd1);
        check("hs.start_in_done_mul", bus32.mul_o, 64'hFFFF_FFFF_FFFF_FFEB);
        bus32.start_i = 1'b1; bus32.ack_i = 1'b1;
        @(negedge clk);
        bus32.start_i = 1'b0; bus32.ack_i = 1'b0;
        check("hs.ack_busy", 64'(bus32.busy_o), 64'd0);
        check("hs.ack_valid", 64'(bus32.valid_o), 64'd0);
        @(negedge clk);
        check("hs.no_restart", 64'(bus32.busy_o), 64'd0);
        check("hs.idle_mul_hold", bus32.mul_o, 64'hFFFF_FFFF_FFFF_FFEB);
        check("hs.idle_flag_hold", 64'(bus32.flag_o), 64'd0);

        // Reset in the middle of CALC
        start32(32'h1234, 32'h10, 2'b00);
        repeat (14) @(negedge clk);
        check("rmid.busy_before", 64'(bus32.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rmid.mul",   bus32.mul_o, 64'h0);
        check("rmid.flag",  64'(bus32.flag_o), 64'd0);
        check("rmid.valid", 64'(bus32.valid_o), 64'd0);
        check("rmid.busy",  64'(bus32.busy_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rmid.idle_after", 64'(bus32.busy_o), 64'd0);
        run32(32'd3, 32'd5, 2'b00, 64'd15, 1'b0, "r3x5");

        // XLEN=8 instance
        bus8.start_i = 1'b1; bus8.rs1_i = 8'd7; bus8.rs2_i = 8'hFD; bus8.mode_i = 2'b01;
        @(negedge clk);
        bus8.start_i = 1'b0;
        lat = 0;
        while (!bus8.valid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("x8.latency", 64'(lat), 64'd9);
        check("x8.mul", 64'(bus8.mul_o), 64'hFFEB);
        check("x8.flag", 64'(bus8.flag_o), 64'd0);
        bus8.ack_i = 1'b1;
        @(negedge clk);
        bus8.ack_i = 1'b0;
        check("x8.busy_after_ack", 64'(bus8.busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand width (legal range 4..64, even).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: request to multiply; sampled only in IDLE.
REQ-005 SHALL have port rs1_i, input, XLEN bits: multiplicand; sampled with start_i.
REQ-006 SHALL have port rs2_i, input, XLEN bits: multiplier; sampled with start_i.
REQ-007 SHALL have port mode_i, input, 2 bits: 00 unsigned×unsigned, 01 signed×signed, 10 signed(rs1)×unsigned(rs2), 11 treated as 01; sampled with start_i.
REQ-008 SHALL have port busy_o, output, 1 bit: high in CALC and DONE.
REQ-009 SHALL have port valid_o, output, 1 bit: result available (DONE).
REQ-010 SHALL have port ack_i, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port mul_o, output, 2*XLEN bits: full-width product.
REQ-012 SHALL have port flag_o, output, 1 bit: product not representable in XLEN bits under the selected mode.

Function
REQ-013 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-014 SHALL, in IDLE with start_i=1 at an edge, latch the operands extended to XLEN+1 bits (sign-extended if signed per mode_i, else zero-extended), clear the accumulator and the Booth bit Q-1, load the iteration counter with XLEN+1, and enter CALC.
REQ-015 SHALL perform one radix-2 Booth step per CALC cycle using the pair {Q0,Q-1}: 01 adds the multiplicand to the accumulator, 10 subtracts it, 00/11 makes no change; then arithmetic-shift {acc,Q,Q-1} right one bit; then decrement the counter.
REQ-016 SHALL use an accumulator XLEN+2 bits wide so that add/subtract of the extended multiplicand never overflows, including the case of a most-negative operand.
REQ-017 SHALL enter DONE on the edge that completes the (XLEN+1)th step, so that valid_o rises exactly XLEN+1 cycles after the accepting edge.
REQ-018 SHALL drive mul_o with the low 2*XLEN bits of {acc,Q}, held stable throughout DONE.
REQ-019 SHALL set flag_o in DONE as follows: for unsigned mode, high when mul_o[2*XLEN-1:XLEN] != 0; for signed modes, high when mul_o[2*XLEN-1:XLEN-1] is not all-equal bits.
REQ-020 SHALL, in DONE with ack_i=1 at an edge, return to IDLE; valid_o SHALL remain high until that edge.
REQ-021 SHALL ignore start_i in CALC and DONE (no restart, no operand re-sampling); start_i and ack_i high together in DONE SHALL only complete the handshake.
REQ-022 SHALL ignore ack_i outside DONE.
REQ-023 SHALL keep mul_o and flag_o at their last DONE values while in IDLE and CALC; valid_o SHALL be 0 there.
REQ-024 SHALL NOT accept a new start_i in the same cycle that DONE is left; the earliest acceptance is the first IDLE cycle.

Reset
REQ-025 SHALL, on rst_n=0 at any time (including mid-CALC), asynchronously force IDLE, counter=0, accumulator/operands=0, mul_o=0, flag_o=0, valid_o=0, busy_o=0.
REQ-026 SHALL, on rst_n release, require a start_i after release before any computation; an operation interrupted by reset is discarded.

Verification
REQ-027 Signed (XLEN=32): rs1=7, rs2=0xFFFFFFFD, mode=01 -> after 33 cycles valid_o=1, mul_o=0xFFFFFFFF_FFFFFFEB, flag_o=0.
REQ-028 Corner case: rs1=rs2=0x80000000, mode=01 -> mul_o=0x40000000_00000000, flag_o=1; with mode=00 -> mul_o=0x40000000_00000000, flag_o=1.
REQ-029 Unsigned: rs1=rs2=0xFFFFFFFF, mode=00 -> mul_o=0xFFFFFFFE_00000001, flag_o=1; mode=01 -> mul_o=0x00000000_00000001, flag_o=0.
REQ-030 Mixed: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF, mode=10 -> mul_o=0xFFFFFFFF_00000001, flag_o=1.
REQ-031 Handshake: hold ack_i=0 for 10 cycles after valid_o -> mul_o/valid_o stable; pulse start_i with new operands during CALC and during DONE -> ignored; ack_i=1 -> IDLE the next cycle, busy_o=0.
REQ-032 Reset mid-op: assert rst_n=0 at step 15 of CALC -> outputs 0 immediately; after release, start 3×5 mode=00 -> mul_o=15 after 33 cycles; also repeat REQ-027 with XLEN=8 (7×-3 -> 0xFFEB after 9 cycles).
